frac_clk_gen: RTL

- Parametrised, multi-channel, all-digital clock-enable generator. Next generation of the fixed single-output 50 MHz to 25.2 MHz pixel-clock block.
- Each channel is a phase accumulator (NCO) that produces:
  - a one-cycle clock-enable pulse at the average requested frequency;
  - an approximately 50% duty square wave.
- Channel increments can be reprogrammed at run time through a valid/ready interface, so the video path can switch modes (for example 640x480 to 800x600) without a new bitstream.
- A lock counter reports when outputs are stable after reset or reconfiguration.

---
 rtl/frac_clk_gen_if.sv | 24 ++
 rtl/frac_clk_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/frac_clk_gen_if.sv
// Reconfiguration channel of the fractional clock-enable generator:
// a valid/ready request carrying a channel index and its new phase increment.
interface frac_clk_gen_if #(
    parameter int ACC_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        output cfg_ready
    );
endinterface

// File: rtl/frac_clk_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators give
// a one-cycle enable on each wrap plus an MSB square wave; increments are run-time
// reprogrammable and a lock FSM reports when outputs have settled.
module frac_clk_gen #(
    parameter int          NUM_CH      = 2,
    parameter int          ACC_W       = 32,
    parameter int          LOCK_CYCLES = 1024,
    parameter logic [47:0] INC0        = 48'd2164663517,
    parameter logic [47:0] INC1        = 48'd3435973837,
    parameter logic [47:0] INC2        = 48'd0,
    parameter logic [47:0] INC3        = 48'd0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    frac_clk_gen_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKING = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    function automatic logic [ACC_W-1:0] inc_init(input int n);
        logic [ACC_W-1:0] v;
        case (n)
            0:       v = INC0[ACC_W-1:0];
            1:       v = INC1[ACC_W-1:0];
            2:       v = INC2[ACC_W-1:0];
            3:       v = INC3[ACC_W-1:0];
            default: v = '0;
        endcase
        return v;
    endfunction

    // Carry out of the ACC_W+1 wide add is the wrap event that becomes clk_en.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                hs;

    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_d [NUM_CH];
    logic [ACC_W-1:0]    inc_q [NUM_CH];
    logic [ACC_W-1:0]    inc_d [NUM_CH];
    logic [ACC_W:0]      sum   [NUM_CH];
    logic [NUM_CH-1:0]   clk_en_q, clk_en_d;

    // Ready is low only in APPLY (and in reset), so a held request is taken once per two cycles.
    assign hs = cfg.cfg_valid & cfg_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOCKING: begin
                if (hs) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (hs) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end
            end
            ST_APPLY: begin
                state_d = ST_LOCKING;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_LOCKING;
                cnt_d   = '0;
            end
        endcase
        cfg_ready_d = (state_d != ST_APPLY);
    end

    // Per-channel NCO; a handshake addressing a non-existent channel matches nothing here.
    always_comb begin
        clk_en_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            sum[n]   = acc_add(acc_q[n], inc_q[n]);
            acc_d[n] = acc_q[n];
            inc_d[n] = inc_q[n];
            if (ch_en[n]) begin
                acc_d[n]    = sum[n][ACC_W-1:0];
                clk_en_d[n] = sum[n][ACC_W];
            end
            if (hs && (int'(cfg.cfg_ch) == n)) begin
                acc_d[n]    = '0;
                inc_d[n]    = cfg.cfg_inc;
                clk_en_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOCKING;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
            clk_en_q    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                acc_q[n] <= '0;
                inc_q[n] <= inc_init(n);
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= cfg_ready_d;
            clk_en_q    <= clk_en_d;
            for (int n = 0; n < NUM_CH; n++) begin
                acc_q[n] <= acc_d[n];
                inc_q[n] <= inc_d[n];
            end
        end
    end

    always_comb begin
        outclk = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            outclk[n] = acc_q[n][ACC_W-1];
        end
    end

    assign clk_en        = clk_en_q;
    assign locked        = (state_q == ST_LOCKED);
    assign cfg.cfg_ready = cfg_ready_q;

endmodule
